pixel_compositor: RTL
=====================

# pixel_compositor

Parametrised per-pixel colour generator for the VGA demoscene pipeline. Sits between the sync/position generator and the output pins. Selects one of nine animated background patterns. Overlays a bouncing sprite fetched from an external sprite ROM, with colour-key transparency. Produces registered R/G/B with a fixed 2-cycle latency from hpos/vpos/visible.

## Interface
Parameters:
- CW, 2: bits per colour channel; pixel word is 3*CW bits, ordered {R,G,B}.
- H_ACTIVE, 640: visible width in pixels.
- V_ACTIVE, 480: visible height in lines.
- SPR_W, 32: sprite width in pixels.
- SPR_H, 32: sprite height in lines.
- SPEED, 1: sprite step in pixels per frame, per axis.
- KEY, 0: 3*CW-bit transparent colour key.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset; synchronous, active-low. Clock is clk.
- hpos, vpos  in  10  current pixel position.
- visible  in  1  high inside the active area.
- vsync  in  1  vertical sync, clk-synchronous level; polarity is active-high.
- mode_in  in  4  requested background mode.
- mode_we  in  1  strobe that captures mode_in.
- solid_in  in  3*CW  colour used by mode 0.
- spr_en  in  1  enables the sprite overlay and its movement.
- spr_addr  out  $clog2(SPR_W*SPR_H)  sprite ROM address, registered.
- spr_pix  in  3*CW  ROM data; valid one cycle after spr_addr.
- R, G, B  out  CW each  registered pixel colour.

## Operation
- Frame tick:
  - frame_tick = vsync & ~vsync_d, where vsync_d is a registered copy of vsync.
  - Nothing is clocked by vsync directly.
- Frame counter: fc[9:0] increments by 1 on each frame_tick and wraps 1023→0.
- Mode register:
  - When mode_we is high, mode_in is captured into mode_pend.
  - mode_pend is copied to mode_act on frame_tick, so mode changes are never visible mid-frame.
  - If mode_we and frame_tick occur in the same cycle, the new mode_in goes to mode_act directly.
- Moving coordinates (10-bit, mod 1024):
  - mode 3: mx = hpos+fc.
  - mode 4: mx = hpos−fc.
  - mode 5: my = vpos+fc.
  - mode 6: my = vpos−fc.
  - mode 7: mx = hpos+fc and my = vpos+fc.
- Background per mode_act. Channel index k is 0 for R, 1 for G, 2 for B. {b×n} means bit b replicated n times.
  - 0: solid_in.
  - 1: hpos[3*CW-1:0].
  - 2: vpos[3*CW-1:0].
  - 3, 4: ch_k = {mx[5+k], {vpos[2]×(CW-1)}}.
  - 5, 6: ch_k = {my[5+k], {vpos[2]×(CW-1)}}.
  - 7: ch_k = {my[5+k], {mx[2]×(CW-1)}}.
  - 8: checker; all-ones if hpos[4]^vpos[4]^fc[5], else all-zeros.
  - 9–15: black.
- Sprite FSM. Per-axis direction bits dx, dy: 1 = increasing, 0 = decreasing. Update on frame_tick only, and only when spr_en is high. X axis (Y is identical, using V_ACTIVE and SPR_H):
  - MAX = H_ACTIVE−SPR_W.
  - dx=1: if sx+SPEED ≥ MAX then sx=MAX and dx=0, else sx += SPEED.
  - dx=0: if sx ≤ SPEED then sx=0 and dx=1, else sx −= SPEED.
- Sprite hit and address:
  - hit = spr_en & visible & (sx ≤ hpos < sx+SPR_W) & (sy ≤ vpos < sy+SPR_H).
  - When hit: spr_addr = (vpos−sy)*SPR_W + (hpos−sx).
  - When not hit: spr_addr holds its previous value.
- Compose:
  - If hit_d && spr_pix != KEY, output spr_pix; otherwise output the background.
  - Output is forced to 0 when visible_d is low.

## Timing
- Stage 1, edge N: register bg, hit, visible and spr_addr computed from the inputs present at edge N.
- Stage 2, edge N+1: register {R,G,B} from the stage-1 registers and spr_pix. Total latency is 2 cycles.
- Values after reset:
  - R, G, B, spr_addr, fc: 0.
  - sx, sy: 0.
  - dx = dy = 1.
  - mode_pend = mode_act = 0.
  - vsync_d = 0.
  - All pipeline registers: 0.
- Reset has priority over frame_tick and mode_we. Asserting reset mid-frame blanks the output from the next edge.
- When spr_en is low, the sprite position freezes and is not reset. Re-enabling spr_en resumes movement from the held position.
- A vsync held high for many cycles produces exactly one frame_tick.

## Test plan
- Reset, then mode 0 with solid_in=6'b110000 and visible=1 → R=3, G=0, B=0 appear 2 cycles after the input. With visible=0 → output 0.
- Mode 3 with fc=5, hpos=27, vpos=4 → mx=32, so R=2'b11, G=2'b01, B=2'b01. Apply mode_we mid-frame → the output must not change until after the next vsync rising edge.
- Bounce with H_ACTIVE=640, SPR_W=32, SPEED=1: run 608 frame ticks → sx=608 and dx=0. After the next tick → sx=607.
- Sprite overlay: sx=sy=0, hpos=3, vpos=2 → spr_addr=67. With spr_pix=6'b001100 → output 6'b001100. With spr_pix=KEY → background is output.
- fc wrap: after 1024 ticks fc=0. A vsync held high for 100 cycles → fc increments by exactly 1.
- Assert rst_n low mid-line → the next output is 0 and sx, sy, fc, dx, dy take their reset values.

Source files
------------

// File: rtl/pixel_compositor.sv
// pixel_compositor: per-pixel background pattern generator with a bouncing,
// colour-keyed sprite overlay. Two register stages from hpos/vpos/visible to R/G/B.
module pixel_compositor #(
   parameter int unsigned CW       = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned SPR_W    = 32,
   parameter int unsigned SPR_H    = 32,
   parameter int unsigned SPEED    = 1,
   parameter logic [3*CW-1:0] KEY  = '0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [9:0]                         hpos,
   input  logic [9:0]                         vpos,
   input  logic                               visible,
   input  logic                               vsync,
   input  logic [3:0]                         mode_in,
   input  logic                               mode_we,
   input  logic [3*CW-1:0]                    solid_in,
   input  logic                               spr_en,
   output logic [$clog2(SPR_W*SPR_H)-1:0]     spr_addr,
   input  logic [3*CW-1:0]                    spr_pix,
   output logic [CW-1:0]                      R,
   output logic [CW-1:0]                      G,
   output logic [CW-1:0]                      B
);

   localparam int unsigned PW    = 3 * CW;
   localparam int unsigned AW    = $clog2(SPR_W * SPR_H);
   localparam int unsigned MAX_X = H_ACTIVE - SPR_W;
   localparam int unsigned MAX_Y = V_ACTIVE - SPR_H;

   // frame timing and mode state
   logic          vsync_d;
   logic          frame_tick;
   logic [9:0]    fc;
   logic [3:0]    mode_pend;
   logic [3:0]    mode_act;

   // sprite position machine
   logic [9:0]    sx, sy;
   logic          dx, dy;
   logic [9:0]    sx_nx, sy_nx;
   logic          dx_nx, dy_nx;
   logic          spr_hit;
   logic [AW-1:0] addr_nx;

   // background path
   logic [9:0]    mx, my;
   logic [PW-1:0] bg;

   // pipeline registers
   logic [PW-1:0] bg_q;
   logic          hit_q;
   logic          vis_q;
   logic [AW-1:0] spr_addr_q;
   logic [PW-1:0] rgb_q;

   // one step of a bouncing axis; returns {dir, pos}
   function automatic logic [10:0] axis_next(input logic [9:0] pos,
                                             input logic       dir,
                                             input logic [9:0] lim);
      logic [9:0] p;
      logic       d;
      p = pos;
      d = dir;
      if (dir) begin
         if ((11'(pos) + 11'(SPEED)) >= 11'(lim)) begin
            p = lim;
            d = 1'b0;
         end else begin
            p = pos + 10'(SPEED);
         end
      end else begin
         if (pos <= 10'(SPEED)) begin
            p = '0;
            d = 1'b1;
         end else begin
            p = pos - 10'(SPEED);
         end
      end
      return {d, p};
   endfunction

   // three-channel pattern: channel MSB from m[5+k], remaining bits from lo
   function automatic logic [PW-1:0] chan_pix(input logic [9:0] m, input logic lo);
      return {m[5], {(CW-1){lo}}, m[6], {(CW-1){lo}}, m[7], {(CW-1){lo}}};
   endfunction

   assign frame_tick = vsync & ~vsync_d;

   // vsync edge detector, frame counter and frame-aligned mode update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_d   <= 1'b0;
         fc        <= '0;
         mode_pend <= '0;
         mode_act  <= '0;
      end else begin
         vsync_d <= vsync;
         if (frame_tick) begin
            fc       <= fc + 10'd1;
            mode_act <= mode_we ? mode_in : mode_pend;
         end
         if (mode_we) begin
            mode_pend <= mode_in;
         end
      end
   end

   // sprite state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sx <= '0;
         sy <= '0;
         dx <= 1'b1;
         dy <= 1'b1;
      end else begin
         sx <= sx_nx;
         sy <= sy_nx;
         dx <= dx_nx;
         dy <= dy_nx;
      end
   end

   // sprite next state: moves once per frame while enabled, otherwise frozen
   always_comb begin
      sx_nx = sx;
      sy_nx = sy;
      dx_nx = dx;
      dy_nx = dy;
      if (frame_tick && spr_en) begin
         {dx_nx, sx_nx} = axis_next(sx, dx, 10'(MAX_X));
         {dy_nx, sy_nx} = axis_next(sy, dy, 10'(MAX_Y));
      end
   end

   // sprite outputs: hit test and ROM address for the current pixel
   always_comb begin
      logic in_x;
      logic in_y;
      logic [9:0] rel_x;
      logic [9:0] rel_y;
      in_x    = (hpos >= sx) && (11'(hpos) < (11'(sx) + 11'(SPR_W)));
      in_y    = (vpos >= sy) && (11'(vpos) < (11'(sy) + 11'(SPR_H)));
      spr_hit = spr_en && visible && in_x && in_y;
      rel_x   = hpos - sx;
      rel_y   = vpos - sy;
      addr_nx = AW'((32'(rel_y) * 32'(SPR_W)) + 32'(rel_x));
   end

   // scrolled coordinates for the moving patterns
   always_comb begin
      mx = hpos;
      my = vpos;
      case (mode_act)
         4'd3: mx = hpos + fc;
         4'd4: mx = hpos - fc;
         4'd5: my = vpos + fc;
         4'd6: my = vpos - fc;
         4'd7: begin
            mx = hpos + fc;
            my = vpos + fc;
         end
         default: ;
      endcase
   end

   // background pattern selection
   always_comb begin
      bg = '0;
      case (mode_act)
         4'd0:       bg = solid_in;
         4'd1:       bg = PW'(hpos);
         4'd2:       bg = PW'(vpos);
         4'd3, 4'd4: bg = chan_pix(mx, vpos[2]);
         4'd5, 4'd6: bg = chan_pix(my, vpos[2]);
         4'd7:       bg = chan_pix(my, mx[2]);
         4'd8:       bg = (hpos[4] ^ vpos[4] ^ fc[5]) ? '1 : '0;
         default:    bg = '0;
      endcase
   end

   // stage 1: background, hit, visibility and ROM address
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bg_q       <= '0;
         hit_q      <= 1'b0;
         vis_q      <= 1'b0;
         spr_addr_q <= '0;
      end else begin
         bg_q  <= bg;
         hit_q <= spr_hit;
         vis_q <= visible;
         if (spr_hit) begin
            spr_addr_q <= addr_nx;
         end
      end
   end

   // stage 2: sprite over background unless keyed out, blanked outside active area
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb_q <= '0;
      end else if (!vis_q) begin
         rgb_q <= '0;
      end else if (hit_q && (spr_pix != KEY)) begin
         rgb_q <= spr_pix;
      end else begin
         rgb_q <= bg_q;
      end
   end

   assign spr_addr = spr_addr_q;
   assign R        = rgb_q[3*CW-1:2*CW];
   assign G        = rgb_q[2*CW-1:CW];
   assign B        = rgb_q[CW-1:0];

endmodule
